// File: rtl/jr_commit_restore_pkg.sv
// Shared types and defaults for the commit-side RAS restore logic.
// Build-time overrides: JR_ENTRIES, JR_ENTRY_WIDTH, JR_STACK_INIT.
`ifndef JR_ENTRIES
`define JR_ENTRIES 8
`endif
`ifndef JR_ENTRY_WIDTH
`define JR_ENTRY_WIDTH 3
`endif
`ifndef JR_STACK_INIT
`define JR_STACK_INIT 32'h0000_0000
`endif

package jr_commit_restore_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned DefEntries    = `JR_ENTRIES;
    localparam int unsigned DefEntryWidth = `JR_ENTRY_WIDTH;
    localparam word_t       StackInit     = `JR_STACK_INIT;

    typedef enum logic [1:0] {IDLE, SYNC, STREAM} jr_restore_state_t;

    // Add 0..2 to a counter, sticking at all-ones.
    function automatic word_t sat_add(word_t a, logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/jr_commit_restore_arch_stack.sv
// Architectural RAS copy: two-slot in-order push/pop next-state plus registers.
// Read port returns the post-commit value of the indexed entry.
// JR_RESTORE_STATS_EN adds the per-slot pre-pop top-of-stack outputs.
module jr_arch_stack
    import jr_commit_restore_pkg::*;
#(
    parameter int unsigned ENTRIES     = DefEntries,
    parameter int unsigned ENTRY_WIDTH = DefEntryWidth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             c_valid,
    input  logic [1:0]             c_call,
    input  logic [1:0]             c_ret,
    input  word_t [1:0]            c_link,
    input  logic [ENTRY_WIDTH-1:0] rd_idx,
    output word_t                  rd_data,
    output logic [ENTRY_WIDTH-1:0] top_next,
`ifdef JR_RESTORE_STATS_EN
    output word_t [1:0]            tos,
`endif
    output logic                   changed
);

    word_t                  stack_q [ENTRIES];
    word_t                  stack_d [ENTRIES];
    logic [ENTRY_WIDTH-1:0] top_q;
    logic [ENTRY_WIDTH-1:0] top_d;

    // Apply slot 0 then slot 1 to a working copy of the stack.
    always_comb begin
        stack_d = stack_q;
        top_d   = top_q;
`ifdef JR_RESTORE_STATS_EN
        tos     = '0;
`endif
        for (int s = 0; s < 2; s++) begin
`ifdef JR_RESTORE_STATS_EN
            tos[s] = stack_d[top_d];
`endif
            if (c_valid[s]) begin
                if (c_call[s] && c_ret[s]) begin
                    stack_d[top_d] = c_link[s];
                end else if (c_call[s]) begin
                    top_d          = top_d + ENTRY_WIDTH'(1);
                    stack_d[top_d] = c_link[s];
                end else if (c_ret[s]) begin
                    stack_d[top_d] = '0;
                    top_d          = top_d - ENTRY_WIDTH'(1);
                end
            end
        end
    end

    // Flag any cycle in which committed instructions alter architectural state.
    always_comb begin
        changed = (top_d != top_q);
        for (int i = 0; i < ENTRIES; i++) begin
            if (stack_d[i] != stack_q[i]) changed = 1'b1;
        end
    end

    assign rd_data  = stack_d[rd_idx];
    assign top_next = top_d;

    // Architectural state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            for (int i = 0; i < ENTRIES; i++) stack_q[i] <= StackInit;
        end else begin
            top_q   <= top_d;
            stack_q <= stack_d;
        end
    end

endmodule

// File: rtl/jr_commit_restore.sv
// Commit-side RAS: keeps the architectural stack and rebuilds the fetch RAS
// after a flush (top pointer pulse, then one entry per cycle).
// JR_RESTORE_STATS_EN adds return-target hit/miss counters.
module jr_commit_restore
    import jr_commit_restore_pkg::*;
#(
    parameter int unsigned ENTRIES     = DefEntries,
    parameter int unsigned ENTRY_WIDTH = DefEntryWidth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             c_valid,
    input  logic [1:0]             c_call,
    input  logic [1:0]             c_ret,
    input  word_t [1:0]            c_link,
`ifdef JR_RESTORE_STATS_EN
    input  word_t [1:0]            c_ret_tgt,
    output word_t                  ret_hit,
    output word_t                  ret_miss,
`endif
    input  logic                   flush,
    output logic                   top_reset,
    output logic [ENTRY_WIDTH-1:0] top_commit,
    output logic                   rst_valid,
    output logic [ENTRY_WIDTH-1:0] rst_idx,
    output word_t                  rst_addr,
    output logic                   busy
);

    localparam logic [ENTRY_WIDTH-1:0] LastIdx = ENTRY_WIDTH'(ENTRIES - 1);

    jr_restore_state_t      state_q;
    logic [ENTRY_WIDTH-1:0] idx_q;
    logic                   dirty_q;
    logic                   changed;
    word_t                  rd_data;
`ifdef JR_RESTORE_STATS_EN
    word_t [1:0]            tos;
`endif

    jr_arch_stack #(
        .ENTRIES     (ENTRIES),
        .ENTRY_WIDTH (ENTRY_WIDTH)
    ) u_arch_stack (
        .clk      (clk),
        .reset    (reset),
        .c_valid  (c_valid),
        .c_call   (c_call),
        .c_ret    (c_ret),
        .c_link   (c_link),
        .rd_idx   (idx_q),
        .rd_data  (rd_data),
        .top_next (top_commit),
`ifdef JR_RESTORE_STATS_EN
        .tos      (tos),
`endif
        .changed  (changed)
    );

    // Restore sequencer; a commit mid-stream forces another full pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush) state_q <= SYNC;
                end
                SYNC: begin
                    // Commits here are already folded into top_commit.
                    dirty_q <= 1'b0;
                    idx_q   <= '0;
                    if (!flush) state_q <= STREAM;
                end
                STREAM: begin
                    if (flush) begin
                        state_q <= SYNC;
                        idx_q   <= '0;
                        dirty_q <= 1'b0;
                    end else if (idx_q == LastIdx) begin
                        state_q <= (dirty_q || changed) ? SYNC : IDLE;
                        idx_q   <= '0;
                        dirty_q <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + ENTRY_WIDTH'(1);
                        dirty_q <= dirty_q || changed;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decoded straight from the state register.
    assign top_reset = (state_q == SYNC);
    assign rst_valid = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign rst_idx   = idx_q;
    assign rst_addr  = rst_valid ? rd_data : '0;

`ifdef JR_RESTORE_STATS_EN
    logic [1:0] is_ret;
    logic [1:0] hit;
    logic [1:0] miss;
    word_t      hit_q;
    word_t      miss_q;

    // Classify each committed return against the pre-pop top of stack.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            is_ret[s] = c_valid[s] && c_ret[s];
            hit[s]    = is_ret[s] && (c_ret_tgt[s] == tos[s]);
            miss[s]   = is_ret[s] && (c_ret_tgt[s] != tos[s]);
        end
    end

    // Saturating hit/miss counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= sat_add(hit_q, {1'b0, hit[0]} + {1'b0, hit[1]});
            miss_q <= sat_add(miss_q, {1'b0, miss[0]} + {1'b0, miss[1]});
        end
    end

    assign ret_hit  = hit_q;
    assign ret_miss = miss_q;
`endif

endmodule

// File: tb/tb_jr_commit_restore.sv
// Directed bench for jr_commit_restore (default 8-entry build).
module tb_jr_commit_restore;
    import jr_commit_restore_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  c_valid;
    logic [1:0]  c_call;
    logic [1:0]  c_ret;
    word_t [1:0] c_link;
    logic        flush;
    logic        top_reset;
    logic [2:0]  top_commit;
    logic        rst_valid;
    logic [2:0]  rst_idx;
    word_t       rst_addr;
    logic        busy;
`ifdef JR_RESTORE_STATS_EN
    word_t [1:0] c_ret_tgt;
    word_t       ret_hit;
    word_t       ret_miss;
`endif

    int    n_checks = 0;
    int    n_err    = 0;
    word_t exp_stk [8];
    word_t link;

    jr_commit_restore dut (
        .clk        (clk),
        .reset      (reset),
        .c_valid    (c_valid),
        .c_call     (c_call),
        .c_ret      (c_ret),
        .c_link     (c_link),
`ifdef JR_RESTORE_STATS_EN
        .c_ret_tgt  (c_ret_tgt),
        .ret_hit    (ret_hit),
        .ret_miss   (ret_miss),
`endif
        .flush      (flush),
        .top_reset  (top_reset),
        .top_commit (top_commit),
        .rst_valid  (rst_valid),
        .rst_idx    (rst_idx),
        .rst_addr   (rst_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        c_valid = '0;
        c_call  = '0;
        c_ret   = '0;
        c_link  = '0;
        flush   = 1'b0;
`ifdef JR_RESTORE_STATS_EN
        c_ret_tgt = '0;
`endif
    endtask

    // Called in the SYNC cycle; checks the pulse and the full stream.
    task automatic restore(input string tag, input logic [31:0] exp_top);
        chk({tag, " top_reset"}, 32'(top_reset), 1);
        chk({tag, " top_commit"}, 32'(top_commit), exp_top);
        chk({tag, " sync busy"}, 32'(busy), 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk({tag, " rst_valid"}, 32'(rst_valid), 1);
            chk({tag, " rst_idx"}, 32'(rst_idx), 32'(i));
            chk({tag, " rst_addr"}, rst_addr, exp_stk[i]);
            chk({tag, " stream busy"}, 32'(busy), 1);
            tick();
        end
        chk({tag, " busy drop"}, 32'(busy), 0);
        chk({tag, " rst_valid drop"}, 32'(rst_valid), 0);
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_stk[i] = 32'h0;

        // T1: idle after reset
        repeat (10) tick();
        chk("t1 busy", 32'(busy), 0);
        chk("t1 top_reset", 32'(top_reset), 0);
        chk("t1 rst_valid", 32'(rst_valid), 0);
        chk("t1 top_commit", 32'(top_commit), 0);
        chk("t1 rst_idx", 32'(rst_idx), 0);
        chk("t1 rst_addr", rst_addr, 0);

        // T2: dual call, then flush
        c_valid = 2'b11;
        c_call  = 2'b11;
        c_link[0] = 32'h8000_0010;
        c_link[1] = 32'h8000_0020;
        tick();
        clear_in();
        flush = 1'b1;
        #1;
        chk("t2 flush-cycle busy", 32'(busy), 0);
        tick();
        flush = 1'b0;
        #1;
        exp_stk[1] = 32'h8000_0010;
        exp_stk[2] = 32'h8000_0020;
        restore("t2", 2);

        // T3: ret in slot 0, call in slot 1, flush in the same cycle
        c_valid   = 2'b11;
        c_ret     = 2'b01;
        c_call    = 2'b10;
        c_link[1] = 32'hBFC0_0100;
        flush     = 1'b1;
        #1;
        tick();
        clear_in();
        #1;
        exp_stk[2] = 32'hBFC0_0100;
        restore("t3", 2);

        // Reset in the middle of a stream
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("rst-mid streaming", 32'(rst_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst-mid busy", 32'(busy), 0);
        chk("rst-mid rst_valid", 32'(rst_valid), 0);
        chk("rst-mid top_reset", 32'(top_reset), 0);
        chk("rst-mid rst_idx", 32'(rst_idx), 0);
        chk("rst-mid rst_addr", rst_addr, 0);
        chk("rst-mid top_commit", 32'(top_commit), 0);

        // T4: nine calls wrap the top pointer to 1
        for (int i = 0; i < 8; i++) exp_stk[i] = 32'h0;
        for (int k = 1; k <= 9; k++) begin
            link      = 32'h0040_0000 + 32'(k * 8);
            c_valid   = 2'b01;
            c_call    = 2'b01;
            c_link[0] = link;
            exp_stk[k % 8] = link;
            tick();
        end
        clear_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        restore("t4", 1);

`ifdef JR_RESTORE_STATS_EN
        // T6: matching then mismatching return target
        c_valid      = 2'b01;
        c_ret        = 2'b01;
        c_ret_tgt[0] = exp_stk[1];
        tick();
        c_ret_tgt[0] = 32'hDEAD_BEEF;
        tick();
        clear_in();
        #1;
        chk("t6 ret_hit", ret_hit, 1);
        chk("t6 ret_miss", ret_miss, 1);
`endif

        // T5: flush mid-stream, then a commit forces a second pass
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_stk[i] = 32'h0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t5 sync1", 32'(top_reset), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) flush = 1'b1;
            #1;
            chk("t5 s1 rst_idx", 32'(rst_idx), 32'(i));
            chk("t5 s1 busy", 32'(busy), 1);
            tick();
            flush = 1'b0;
        end
        #1;
        chk("t5 resync top_reset", 32'(top_reset), 1);
        chk("t5 resync busy", 32'(busy), 1);
        chk("t5 resync top_commit", 32'(top_commit), 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                c_valid   = 2'b01;
                c_call    = 2'b01;
                c_link[0] = 32'h1234_5670;
            end
            #1;
            chk("t5 s2 rst_valid", 32'(rst_valid), 1);
            chk("t5 s2 rst_idx", 32'(rst_idx), 32'(i));
            chk("t5 s2 rst_addr", rst_addr, 0);
            chk("t5 s2 busy", 32'(busy), 1);
            tick();
            clear_in();
        end
        #1;
        exp_stk[1] = 32'h1234_5670;
        restore("t5 dirty pass", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
